// File: rtl/elastic_buffer_pkg.sv
// Shared sizing helpers and parameter legality rules for elastic_buffer.
package elastic_buffer_pkg;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   // Occupancy spans 0..DEPTH inclusive, hence DEPTH+1 codes.
   function automatic int count_w(input int depth);
      return clog2(depth + 1);
   endfunction

   function automatic int ptr_w(input int depth);
      int w;
      w = clog2(depth - 1);
      return (w < 1) ? 1 : w;
   endfunction

   function automatic bit params_ok(input int depth, input int thresh);
      return (depth >= 2) && (thresh >= 1) && (thresh <= depth);
   endfunction

endpackage

// File: rtl/elastic_buffer_mem.sv
// Circular store behind the output register: one synchronous write, one combinational read.
module elastic_buffer_mem
   import elastic_buffer_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ENTRIES    = 3,
   parameter int PTR_W      = 2
) (
   input  logic                  clk,
   input  logic                  i_wr_en,
   input  logic [PTR_W-1:0]      i_wr_addr,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   input  logic [PTR_W-1:0]      i_rd_addr,
   output logic [DATA_WIDTH-1:0] o_rd_data
);

   logic [DATA_WIDTH-1:0] r_mem [ENTRIES];

   always_ff @(posedge clk) begin
      if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
   end

   assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/elastic_buffer.sv
// DEPTH-entry valid/ready elastic buffer with registered outputs and occupancy flags.
// Optional stall counter output enabled by defining ELASTIC_BUFFER_STALL_CNT_EN.
module elastic_buffer
   import elastic_buffer_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int DEPTH        = 4,
   parameter int AFULL_THRESH = 3
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        s_valid,
   output logic                        s_ready,
   input  logic [DATA_WIDTH-1:0]       s_data,
   output logic                        m_valid,
   input  logic                        m_ready,
   output logic [DATA_WIDTH-1:0]       m_data,
   output logic [count_w(DEPTH)-1:0]   count,
   output logic                        almost_full
`ifdef ELASTIC_BUFFER_STALL_CNT_EN
  ,output logic [31:0]                 stall_cnt
`endif
);

   localparam int COUNT_W = count_w(DEPTH);
   localparam int PTR_W   = ptr_w(DEPTH);
   localparam int ENTRIES = DEPTH - 1;

   if (!params_ok(DEPTH, AFULL_THRESH)) begin : g_bad_params
      $error("elastic_buffer: DEPTH must be >= 2 and AFULL_THRESH in 1..DEPTH");
   end

   logic                  r_m_valid;
   logic [DATA_WIDTH-1:0] r_m_data;
   logic                  r_s_ready;
   logic [COUNT_W-1:0]    r_count;
   logic                  r_afull;
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;

   logic                  w_push;
   logic                  w_pop;
   logic                  w_store_empty;
   logic                  w_push_out;
   logic                  w_wr_en;
   logic                  w_load_store;
   logic [COUNT_W-1:0]    w_count_next;
   logic [DATA_WIDTH-1:0] w_rd_data;

   function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(ENTRIES - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign w_push        = s_valid & r_s_ready;
   assign w_pop         = r_m_valid & m_ready;
   // The output register always fills first, so the store holds count-1 beats.
   assign w_store_empty = (r_count <= COUNT_W'(1));
   assign w_push_out    = w_push & (~r_m_valid | (w_pop & w_store_empty));
   assign w_wr_en       = w_push & ~w_push_out;
   assign w_load_store  = w_pop & ~w_store_empty;
   assign w_count_next  = r_count + COUNT_W'(w_push) - COUNT_W'(w_pop);

   elastic_buffer_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .ENTRIES    (ENTRIES),
      .PTR_W      (PTR_W)
   ) u_mem (
      .clk       (clk),
      .i_wr_en   (w_wr_en),
      .i_wr_addr (r_wr_ptr),
      .i_wr_data (s_data),
      .i_rd_addr (r_rd_ptr),
      .o_rd_data (w_rd_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_m_valid <= 1'b0;
         r_m_data  <= '0;
         r_s_ready <= 1'b0;
         r_count   <= '0;
         r_afull   <= 1'b0;
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
      end else begin
         r_count   <= w_count_next;
         r_s_ready <= (w_count_next < COUNT_W'(DEPTH));
         r_afull   <= (w_count_next >= COUNT_W'(AFULL_THRESH));
         if (w_wr_en) r_wr_ptr <= f_inc(r_wr_ptr);
         // Refill from the store on the pop edge so the stream has no bubbles.
         if (w_load_store) begin
            r_m_data <= w_rd_data;
            r_rd_ptr <= f_inc(r_rd_ptr);
         end else if (w_push_out) begin
            r_m_data  <= s_data;
            r_m_valid <= 1'b1;
         end else if (w_pop) begin
            r_m_valid <= 1'b0;
         end
      end
   end

   assign s_ready     = r_s_ready;
   assign m_valid     = r_m_valid;
   assign m_data      = r_m_data;
   assign count       = r_count;
   assign almost_full = r_afull;

`ifdef ELASTIC_BUFFER_STALL_CNT_EN
   logic [31:0] r_stall_cnt;

   always_ff @(posedge clk) begin
      if (rst)                                              r_stall_cnt <= '0;
      else if (r_m_valid & ~m_ready & (r_stall_cnt != '1))  r_stall_cnt <= r_stall_cnt + 32'd1;
   end

   assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: doc/elastic_buffer.md
Name: elastic_buffer

Overview:
- Parametrised successor of the two-entry skid stage: a DEPTH-entry elastic buffer on a valid/ready stream.
- Registered outputs (m_valid, m_data, s_ready), so it can break timing paths in either direction between systolic-array feeders and PE rows.
- Full throughput: one beat per cycle in steady state, including when the buffer is full.
- Exposes occupancy and an almost-full flag for upstream credit and throttling logic.

Parameters:
- DATA_WIDTH, 32, payload width in bits.
- DEPTH, 4, total capacity in beats including the output register; legal range is 2 or more, any integer.
- AFULL_THRESH, 3, almost_full asserts when count >= AFULL_THRESH; legal range 1..DEPTH.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  upstream beat valid.
- s_ready  out  1  registered; buffer can accept a beat this cycle.
- s_data  in  DATA_WIDTH  upstream payload.
- m_valid  out  1  registered; output beat valid.
- m_ready  in  1  downstream accepts the beat.
- m_data  out  DATA_WIDTH  registered output payload.
- count  out  $clog2(DEPTH+1)  registered number of beats held, range 0..DEPTH.
- almost_full  out  1  registered; equals count >= AFULL_THRESH.

Behaviour:
- Reset values: m_valid=0, m_data=0, s_ready=0, count=0, almost_full=0; pointers=0. Storage contents are don't-care.
- s_ready is low during reset and rises on the first clock edge after rst deasserts.
- Handshakes: push = s_valid & s_ready; pop = m_valid & m_ready.
- Structure: output register plus a (DEPTH-1)-entry circular store with wr_ptr/rd_ptr. Each pointer wraps from DEPTH-2 to 0; explicit wrap, no power-of-two requirement.
- Push routing:
  - Output register empty, or popped this cycle while the store is empty: push goes straight to the output register. First-beat latency is 1 cycle: push at edge t gives m_valid=1 with that data after edge t.
  - Otherwise: push is written to store[wr_ptr].
- Pop with store non-empty: output register loads store[rd_ptr] on the same edge, so there are no bubbles.
- count_next = count + push - pop. s_ready <= (count_next < DEPTH). This is exact, so overflow is impossible.
- Full case: when count == DEPTH, s_ready=0. A pop alone gives count=DEPTH-1 and s_ready=1 next cycle. After that, simultaneous push+pop holds count at DEPTH-1 with 100% throughput.
- Empty case: m_valid=0 and m_data holds its last value. No pop can occur.
- Stability: while m_valid & ~m_ready, m_data and m_valid hold stable. Downstream sees no retraction.
- s_valid with s_ready=0: no effect. s_data is ignored and no state changes.
- Simultaneous push and pop at count=1 with the store empty: the output register loads s_data and count stays 1.
- Ordering: strict FIFO, with no drop and no duplication.
- rst asserted mid-stream: all in-flight beats are discarded and every output returns to its reset value on that edge.
- almost_full is registered from count_next, so it is coincident with count.

Optional Feature:
- Macro: ELASTIC_BUFFER_STALL_CNT_EN.
- Defined: adds output stall_cnt (out, 32 bits). It increments each cycle with m_valid & ~m_ready, saturates at 2^32-1, and clears on rst.
- Not defined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package/header: the clog2 constant function, COUNT_W = $clog2(DEPTH+1), PTR_W = $clog2(DEPTH-1) (minimum 1), and the parameter legality checks (elaboration-time $error on a bad DEPTH or AFULL_THRESH).
- One sub-module: elastic_buffer_mem, a (DEPTH-1) x DATA_WIDTH array with 1 synchronous write port and 1 combinational read port; no reset on the array.
- Control, pointers and the output register stay in elastic_buffer.

Test Plan:
- DEPTH=4: single push of 0xA5A5_0001 with m_ready=1 -> m_valid=1 with that data 1 cycle later, count 1 then 0, s_ready stays 1.
- DEPTH=4, m_ready=0: push 0x1..0x5 back-to-back -> 0x1..0x4 accepted, s_ready=0 after 4th push, count=4, almost_full=1 from count=3, 0x5 held upstream. Then m_ready=1 -> output order 0x1,0x2,0x3,0x4,0x5.
- Full buffer with s_valid=1 and m_ready=1 continuously for 20 cycles -> one bubble on the s_ready side only; after that count=3 steady, one beat per cycle each side, order preserved.
- Random s_valid/m_ready at 50% for 10k beats, DEPTH=3 (non-power-of-two) -> scoreboard match, m_data stable whenever m_valid & ~m_ready, count never exceeds 3.
- Assert rst with count=3 -> next cycle m_valid=0, count=0, s_ready=0, then s_ready=1 one cycle after release; stale data is never emitted.
- ELASTIC_BUFFER_STALL_CNT_EN defined, m_valid=1 and m_ready=0 for 7 cycles -> stall_cnt=7; rst -> 0.
